// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg                                                              |
// | Shared definitions for the MEM stage: funct3 access encodings, the   |
// | bus FSM state type and the byte-lane helper functions.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0]  strb;
    logic [31:0] data;
  } lane_t;

  // Extract the addressed byte/half from a read word and extend it.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      F3_B:    load_ext = {{24{s[7]}}, s[7:0]};
      F3_H:    load_ext = {{16{s[15]}}, s[15:0]};
      F3_BU:   load_ext = {24'h000000, s[7:0]};
      F3_HU:   load_ext = {16'h0000, s[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  // Replicate store data across lanes and build the matching strobe.
  function automatic lane_t store_lane(input logic [2:0]  f3,
                                       input logic [1:0]  off,
                                       input logic [31:0] d);
    lane_t r;
    case (f3)
      F3_B: begin
        r.strb = 4'b0001 << off;
        r.data = {4{d[7:0]}};
      end
      F3_H: begin
        r.strb = 4'b0011 << off;
        r.data = {2{d[15:0]}};
      end
      default: begin
        r.strb = 4'b1111;
        r.data = d;
      end
    endcase
    return r;
  endfunction

  // Halfwords need a[0]==0, words need a[1:0]==0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] off);
    case (f3[1:0])
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align                                                            |
// | Combinational byte-lane logic: store strobe/data placement, load     |
// | extraction/extension and misalignment detection.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_align
  import mem_pkg::*;
#(
  parameter int MISALIGN_TRAP = 1
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0] off;
  lane_t      lane;

  // Without trapping, misaligned low address bits are cleared so the access
  // lands on the naturally aligned lanes of the same word.
  always_comb begin
    misaligned = is_misaligned(funct3, addr_lo);
    off        = addr_lo;
    if (MISALIGN_TRAP == 0) begin
      if (funct3[1:0] == 2'b10)      off = 2'b00;
      else if (funct3[1:0] == 2'b01) off[0] = 1'b0;
    end
    lane      = store_lane(funct3, off, store_data);
    wstrb     = lane.strb;
    wdata     = lane.data;
    load_data = load_ext(rdata, off, funct3);
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage                                                            |
// | MEM pipeline stage: EX/MEM register, valid/ready data-memory port,   |
// | MEM forwarding, MEM/WB register and pipeline stall generation.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [5:0]      i_mnemonic,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_rd_wr,
  input  logic [XLEN-1:0] i_ALUout,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_DM_OE,
  input  logic            i_store,
  input  logic [2:0]      i_funct3,
  output logic            o_dm_req_valid,
  input  logic            i_dm_req_ready,
  output logic            o_dm_req_we,
  output logic [XLEN-1:0] o_dm_addr,
  output logic [3:0]      o_dm_wstrb,
  output logic [XLEN-1:0] o_dm_wdata,
  input  logic            i_dm_rsp_valid,
  input  logic [XLEN-1:0] i_dm_rdata,
  output logic [4:0]      o_mem_rd_addr,
  output logic [XLEN-1:0] o_mem_rd_data,
  output logic            o_mem_rd_wr,
  output logic [4:0]      o_wb_rd_addr,
  output logic [XLEN-1:0] o_wb_rd_data,
  output logic            o_wb_rd_wr,
  output logic            o_mem_stall,
  output logic            o_misaligned
);

  // The mnemonic is only meaningful upstream; nothing here decodes it.
  logic unused_mnemonic;
  assign unused_mnemonic = ^i_mnemonic;

  // EX/MEM register contents
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_wr;
  logic [XLEN-1:0] ex_alu;
  logic [XLEN-1:0] ex_rs2;
  logic            ex_load;
  logic            ex_store;
  logic [2:0]      ex_funct3;

  state_t          state;

  logic [3:0]      al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;
  logic            al_mis;

  logic            mem_op;
  logic            trap;
  logic            req;
  logic            done;

  mem_align #(
    .MISALIGN_TRAP (MISALIGN_TRAP)
  ) u_align (
    .funct3     (ex_funct3),
    .addr_lo    (ex_alu[1:0]),
    .store_data (ex_rs2),
    .rdata      (i_dm_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  // A trapped misaligned access never reaches the bus and flows through
  // like an ALU op; the response in WAIT releases the stall the same cycle.
  always_comb begin
    mem_op         = ex_load | ex_store;
    trap           = (MISALIGN_TRAP != 0) && mem_op && al_mis;
    req            = mem_op & ~trap;
    done           = (state == WAIT) & i_dm_rsp_valid;
    o_mem_stall    = req & ~done;
    o_dm_req_valid = req & (state == IDLE);
    o_dm_req_we    = req & ex_store;
    o_dm_addr      = req ? {ex_alu[XLEN-1:2], 2'b00} : '0;
    o_dm_wstrb     = (req & ex_store) ? al_wstrb : 4'b0000;
    o_dm_wdata     = (req & ex_store) ? al_wdata : '0;
    o_misaligned   = trap;
    o_mem_rd_addr  = ex_rd_addr;
    o_mem_rd_data  = ex_alu;
    o_mem_rd_wr    = ex_rd_wr & ~ex_load & (ex_rd_addr != 5'd0);
  end

  // EX/MEM register: advances whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rd_addr <= '0;
      ex_rd_wr   <= 1'b0;
      ex_alu     <= '0;
      ex_rs2     <= '0;
      ex_load    <= 1'b0;
      ex_store   <= 1'b0;
      ex_funct3  <= '0;
    end else if (!o_mem_stall) begin
      ex_rd_addr <= i_rd_addr;
      ex_rd_wr   <= i_rd_wr;
      ex_alu     <= i_ALUout;
      ex_rs2     <= i_rs2_data;
      ex_load    <= i_DM_OE;
      ex_store   <= i_store;
      ex_funct3  <= i_funct3;
    end
  end

  // Bus FSM: IDLE issues the request, WAIT holds until the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (o_dm_req_valid && i_dm_req_ready) state <= WAIT;
        WAIT:    if (i_dm_rsp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: captures the result as the instruction leaves MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_wb_rd_addr <= '0;
      o_wb_rd_data <= '0;
      o_wb_rd_wr   <= 1'b0;
    end else if (!o_mem_stall) begin
      o_wb_rd_addr <= ex_rd_addr;
      o_wb_rd_data <= ex_load ? al_load : ex_alu;
      o_wb_rd_wr   <= ex_rd_wr & (ex_rd_addr != 5'd0) & ~trap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage                                                         |
// | Directed self-checking bench for mem_stage with hand-computed        |
// | expected values.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  i_mnemonic;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wr;
  logic [31:0] i_ALUout;
  logic [31:0] i_rs2_data;
  logic        i_DM_OE;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic        o_dm_req_valid;
  logic        i_dm_req_ready;
  logic        o_dm_req_we;
  logic [31:0] o_dm_addr;
  logic [3:0]  o_dm_wstrb;
  logic [31:0] o_dm_wdata;
  logic        i_dm_rsp_valid;
  logic [31:0] i_dm_rdata;
  logic [4:0]  o_mem_rd_addr;
  logic [31:0] o_mem_rd_data;
  logic        o_mem_rd_wr;
  logic [4:0]  o_wb_rd_addr;
  logic [31:0] o_wb_rd_data;
  logic        o_wb_rd_wr;
  logic        o_mem_stall;
  logic        o_misaligned;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .XLEN          (32),
    .MISALIGN_TRAP (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_mnemonic     (i_mnemonic),
    .i_rd_addr      (i_rd_addr),
    .i_rd_wr        (i_rd_wr),
    .i_ALUout       (i_ALUout),
    .i_rs2_data     (i_rs2_data),
    .i_DM_OE        (i_DM_OE),
    .i_store        (i_store),
    .i_funct3       (i_funct3),
    .o_dm_req_valid (o_dm_req_valid),
    .i_dm_req_ready (i_dm_req_ready),
    .o_dm_req_we    (o_dm_req_we),
    .o_dm_addr      (o_dm_addr),
    .o_dm_wstrb     (o_dm_wstrb),
    .o_dm_wdata     (o_dm_wdata),
    .i_dm_rsp_valid (i_dm_rsp_valid),
    .i_dm_rdata     (i_dm_rdata),
    .o_mem_rd_addr  (o_mem_rd_addr),
    .o_mem_rd_data  (o_mem_rd_data),
    .o_mem_rd_wr    (o_mem_rd_wr),
    .o_wb_rd_addr   (o_wb_rd_addr),
    .o_wb_rd_data   (o_wb_rd_data),
    .o_wb_rd_wr     (o_wb_rd_wr),
    .o_mem_stall    (o_mem_stall),
    .o_misaligned   (o_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Registers have settled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bubble();
    i_mnemonic = '0; i_rd_addr = '0; i_rd_wr = 1'b0; i_ALUout = '0;
    i_rs2_data = '0; i_DM_OE = 1'b0; i_store = 1'b0; i_funct3 = '0;
  endtask

  // Present one instruction for a single edge, then return to bubbles.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic wr);
    i_DM_OE = ld; i_store = st; i_funct3 = f3; i_ALUout = a;
    i_rs2_data = d; i_rd_addr = rd; i_rd_wr = wr; i_mnemonic = 6'h11;
    tick();
    bubble();
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    i_dm_req_ready = 1'b0;
    i_dm_rsp_valid = 1'b0;
    i_dm_rdata     = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", o_dm_req_valid, 0);
    chk("rst_stall", o_mem_stall, 0);
    chk("rst_wb_wr", o_wb_rd_wr, 0);
    chk("rst_wb_data", o_wb_rd_data, 0);
    chk("rst_fwd_wr", o_mem_rd_wr, 0);
    chk("rst_misal", o_misaligned, 0);

    // SW 0xDEADBEEF @0x100, ready high, response one cycle after handshake
    i_dm_req_ready = 1'b1;
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0);
    #1;
    chk("sw_valid", o_dm_req_valid, 1);
    chk("sw_stall_c1", o_mem_stall, 1);
    chk("sw_we", o_dm_req_we, 1);
    chk("sw_addr", o_dm_addr, 32'h100);
    chk("sw_wstrb", o_dm_wstrb, 4'b1111);
    chk("sw_wdata", o_dm_wdata, 32'hDEADBEEF);
    tick();
    #1;
    chk("sw_wait_valid", o_dm_req_valid, 0);
    chk("sw_stall_c2", o_mem_stall, 1);
    tick();
    i_dm_rsp_valid = 1'b1;
    #1;
    chk("sw_stall_rsp", o_mem_stall, 0);
    tick();
    i_dm_rsp_valid = 1'b0;
    #1;
    chk("sw_no_wb", o_wb_rd_wr, 0);
    chk("sw_idle_valid", o_dm_req_valid, 0);

    // SB 0xA5 @0x103
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 1'b0);
    #1;
    chk("sb_wstrb", o_dm_wstrb, 4'b1000);
    chk("sb_wdata", o_dm_wdata, 32'hA5A5A5A5);
    chk("sb_addr", o_dm_addr, 32'h100);
    tick();
    i_dm_rsp_valid = 1'b1;
    tick();
    i_dm_rsp_valid = 1'b0;

    // SH 0x1234 @0x102
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'hFFFF1234, 5'd0, 1'b0);
    #1;
    chk("sh_wstrb", o_dm_wstrb, 4'b1100);
    chk("sh_wdata", o_dm_wdata, 32'h12341234);
    tick();
    i_dm_rsp_valid = 1'b1;
    tick();
    i_dm_rsp_valid = 1'b0;

    // LB @0x102, rdata 0x00800000
    issue(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 5'd5, 1'b1);
    #1;
    chk("lb_valid", o_dm_req_valid, 1);
    chk("lb_no_fwd", o_mem_rd_wr, 0);
    chk("lb_we", o_dm_req_we, 0);
    tick();
    i_dm_rsp_valid = 1'b1;
    i_dm_rdata     = 32'h00800000;
    tick();
    i_dm_rsp_valid = 1'b0;
    #1;
    chk("lb_data", o_wb_rd_data, 32'hFFFFFF80);
    chk("lb_wr", o_wb_rd_wr, 1);
    chk("lb_rd", o_wb_rd_addr, 5'd5);

    // LBU @0x102, same word
    issue(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 5'd6, 1'b1);
    tick();
    i_dm_rsp_valid = 1'b1;
    tick();
    i_dm_rsp_valid = 1'b0;
    #1;
    chk("lbu_data", o_wb_rd_data, 32'h00000080);

    // LH @0x102, rdata 0x8001xxxx -> sign-extended upper half
    issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 1'b1);
    tick();
    i_dm_rsp_valid = 1'b1;
    i_dm_rdata     = 32'h80017FFF;
    tick();
    i_dm_rsp_valid = 1'b0;
    #1;
    chk("lh_data", o_wb_rd_data, 32'hFFFF8001);

    // LW @0x200 with ready low for three cycles
    i_dm_req_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lw_hold_valid", o_dm_req_valid, 1);
      chk("lw_hold_addr", o_dm_addr, 32'h200);
      chk("lw_hold_stall", o_mem_stall, 1);
      tick();
    end
    i_dm_req_ready = 1'b1;
    #1;
    chk("lw_hs_valid", o_dm_req_valid, 1);
    chk("lw_hs_stall", o_mem_stall, 1);
    tick();
    #1;
    chk("lw_wait_valid", o_dm_req_valid, 0);
    chk("lw_wait_stall", o_mem_stall, 1);
    tick();
    i_dm_rsp_valid = 1'b1;
    i_dm_rdata     = 32'h12345678;
    #1;
    chk("lw_rsp_stall", o_mem_stall, 0);
    chk("lw_rsp_valid", o_dm_req_valid, 0);
    tick();
    i_dm_rsp_valid = 1'b0;
    #1;
    chk("lw_data", o_wb_rd_data, 32'h12345678);
    chk("lw_rd", o_wb_rd_addr, 5'd9);

    // LH @0x101 misaligned: trapped, no bus cycle, no writeback
    issue(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd7, 1'b1);
    #1;
    chk("mis_valid", o_dm_req_valid, 0);
    chk("mis_flag", o_misaligned, 1);
    chk("mis_stall", o_mem_stall, 0);
    tick();
    #1;
    chk("mis_flag_gone", o_misaligned, 0);
    chk("mis_wb_wr", o_wb_rd_wr, 0);

    // ALU op: forwarded from MEM, one cycle to WB
    issue(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd3, 1'b1);
    #1;
    chk("alu_fwd_wr", o_mem_rd_wr, 1);
    chk("alu_fwd_data", o_mem_rd_data, 32'h55);
    chk("alu_fwd_rd", o_mem_rd_addr, 5'd3);
    chk("alu_stall", o_mem_stall, 0);
    tick();
    #1;
    chk("alu_wb_data", o_wb_rd_data, 32'h55);
    chk("alu_wb_wr", o_wb_rd_wr, 1);

    // ALU op to x0: neither forwarded nor written back
    issue(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd0, 1'b1);
    #1;
    chk("x0_fwd_wr", o_mem_rd_wr, 0);
    tick();
    #1;
    chk("x0_wb_wr", o_wb_rd_wr, 0);

    // Reset while waiting for the response; a late response is ignored
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd4, 1'b1);
    tick();
    #1;
    chk("rw_wait_stall", o_mem_stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rw_stall", o_mem_stall, 0);
    chk("rw_valid", o_dm_req_valid, 0);
    chk("rw_addr", o_dm_addr, 0);
    chk("rw_wb_data", o_wb_rd_data, 0);
    chk("rw_wb_wr", o_wb_rd_wr, 0);
    i_dm_rsp_valid = 1'b1;
    i_dm_rdata     = 32'hCAFEF00D;
    tick();
    i_dm_rsp_valid = 1'b0;
    #1;
    chk("late_wb_wr", o_wb_rd_wr, 0);
    chk("late_wb_data", o_wb_rd_data, 0);
    chk("late_stall", o_mem_stall, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
